// File: rtl/tap_ctrl.sv
// rtl/tap_ctrl.sv - IEEE 1149.1 TAP controller state machine with decoded scan strobes
// State codes follow the standard encoding so select can be taken straight from state[3].
module tap_ctrl (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] state,
  output logic       tlr_reset,
  output logic       RunTestIdle,
  output logic       CaptureDR,
  output logic       ShiftDR,
  output logic       UpdateDR,
  output logic       CaptureIR,
  output logic       ShiftIR,
  output logic       UpdateIR,
  output logic       select,
  output logic       tdo_en
);

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0,
    S_EX1DR = 4'h1,
    S_SHDR  = 4'h2,
    S_PAUDR = 4'h3,
    S_SELIR = 4'h4,
    S_UPDDR = 4'h5,
    S_CAPDR = 4'h6,
    S_SELDR = 4'h7,
    S_EX2IR = 4'h8,
    S_EX1IR = 4'h9,
    S_SHIR  = 4'hA,
    S_PAUIR = 4'hB,
    S_RTI   = 4'hC,
    S_UPDIR = 4'hD,
    S_CAPIR = 4'hE,
    S_TLR   = 4'hF
  } tap_state_t;

  tap_state_t r_state;
  logic       r_tdo_en;
  logic       w_shift;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_state <= S_TLR;
    end else begin
      case (r_state)
        S_TLR:   r_state <= TMS ? S_TLR   : S_RTI;
        S_RTI:   r_state <= TMS ? S_SELDR : S_RTI;
        S_SELDR: r_state <= TMS ? S_SELIR : S_CAPDR;
        S_CAPDR: r_state <= TMS ? S_EX1DR : S_SHDR;
        S_SHDR:  r_state <= TMS ? S_EX1DR : S_SHDR;
        S_EX1DR: r_state <= TMS ? S_UPDDR : S_PAUDR;
        S_PAUDR: r_state <= TMS ? S_EX2DR : S_PAUDR;
        S_EX2DR: r_state <= TMS ? S_UPDDR : S_SHDR;
        S_UPDDR: r_state <= TMS ? S_SELDR : S_RTI;
        S_SELIR: r_state <= TMS ? S_TLR   : S_CAPIR;
        S_CAPIR: r_state <= TMS ? S_EX1IR : S_SHIR;
        S_SHIR:  r_state <= TMS ? S_EX1IR : S_SHIR;
        S_EX1IR: r_state <= TMS ? S_UPDIR : S_PAUIR;
        S_PAUIR: r_state <= TMS ? S_EX2IR : S_PAUIR;
        S_EX2IR: r_state <= TMS ? S_UPDIR : S_SHIR;
        S_UPDIR: r_state <= TMS ? S_SELDR : S_RTI;
        default: r_state <= S_TLR;
      endcase
    end
  end

  assign w_shift = (r_state == S_SHDR) || (r_state == S_SHIR);

  // TDO changes on the falling edge, so its enable follows half a period behind the state.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= w_shift;
    end
  end

  assign state       = r_state;
  assign tlr_reset   = (r_state == S_TLR);
  assign RunTestIdle = (r_state == S_RTI);
  assign CaptureDR   = (r_state == S_CAPDR);
  assign ShiftDR     = (r_state == S_SHDR);
  assign UpdateDR    = (r_state == S_UPDDR);
  assign CaptureIR   = (r_state == S_CAPIR);
  assign ShiftIR     = (r_state == S_SHIR);
  assign UpdateIR    = (r_state == S_UPDIR);
  assign select      = r_state[3];
  assign tdo_en      = r_tdo_en;

endmodule

// File: tb/tb_tap_ctrl.sv
// tb/tb_tap_ctrl.sv - scoreboard bench for tap_ctrl driving TMS walks through the TAP graph
module tb_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic [3:0] state;
  logic       tlr_reset, RunTestIdle, CaptureDR, ShiftDR, UpdateDR;
  logic       CaptureIR, ShiftIR, UpdateIR, select, tdo_en;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .state(state),
    .tlr_reset(tlr_reset), .RunTestIdle(RunTestIdle),
    .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
    .CaptureIR(CaptureIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
    .select(select), .tdo_en(tdo_en)
  );

  always #5 TCK = ~TCK;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Expected strobe vector {tlr,rti,cdr,sdr,udr,cir,sir,uir,select} for a state code.
  function automatic logic [8:0] strobes(input logic [3:0] s);
    logic sel;
    sel = (s == 4'hF) || (s == 4'hC) || (s == 4'hE) || (s == 4'hA) ||
          (s == 4'h9) || (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
    return {s == 4'hF, s == 4'hC, s == 4'h6, s == 4'h2, s == 4'h5,
            s == 4'hE, s == 4'hA, s == 4'hD, sel};
  endfunction

  function automatic logic [8:0] obs_strobes();
    return {tlr_reset, RunTestIdle, CaptureDR, ShiftDR, UpdateDR,
            CaptureIR, ShiftIR, UpdateIR, select};
  endfunction

  task automatic step(input logic tms, input logic [3:0] exp_state);
    logic [3:0] e;
    TMS = tms;
    exp_q.push_back(exp_state);
    @(posedge TCK);
    #1;
    e = exp_q.pop_front();
    chk("state", {12'd0, state}, {12'd0, e});
    chk("strobes", {7'd0, obs_strobes()}, {7'd0, strobes(e)});
    @(negedge TCK);
    #1;
    chk("tdo_en", {15'd0, tdo_en}, {15'd0, (e == 4'h2) || (e == 4'hA)});
  endtask

  initial begin
    // reset held from time zero, through a couple of clock edges
    repeat (2) @(negedge TCK);
    #1;
    chk("rst_state", {12'd0, state}, 16'h000F);
    chk("rst_strobes", {7'd0, obs_strobes()}, {7'd0, 9'b1_0000_0001});
    chk("rst_tdo_en", {15'd0, tdo_en}, 16'd0);
    TRST = 1'b1;

    step(1'b0, 4'hC);
    chk("rti_strobe", {15'd0, RunTestIdle}, 16'd1);

    // DR scan with long shift, update, back to Select-DR
    step(1'b1, 4'h7);
    step(1'b0, 4'h6);
    step(1'b0, 4'h2);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h2);
    step(1'b1, 4'h1);
    step(1'b1, 4'h5);
    step(1'b1, 4'h7);

    // Select-IR escape to TLR
    step(1'b1, 4'h4);
    step(1'b1, 4'hF);
    step(1'b0, 4'hC);

    // IR scan with pause/exit2 loop back into shift
    step(1'b1, 4'h7);
    step(1'b1, 4'h4);
    step(1'b0, 4'hE);
    step(1'b0, 4'hA);
    step(1'b1, 4'h9);
    step(1'b0, 4'hB);
    step(1'b1, 4'h8);
    step(1'b0, 4'hA);

    // into Shift-DR, then five ones recover to TLR, a sixth stays there
    step(1'b1, 4'h9);
    step(1'b1, 4'hD);
    step(1'b1, 4'h7);
    step(1'b0, 4'h6);
    step(1'b0, 4'h2);
    step(1'b1, 4'h1);
    step(1'b1, 4'h5);
    step(1'b1, 4'h7);
    step(1'b1, 4'h4);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);

    // async reset mid-shift, between clock edges
    step(1'b0, 4'hC);
    step(1'b1, 4'h7);
    step(1'b0, 4'h6);
    step(1'b0, 4'h2);
    chk("pre_rst_tdo_en", {15'd0, tdo_en}, 16'd1);
    #1 TRST = 1'b0;
    #1;
    chk("async_state", {12'd0, state}, 16'h000F);
    chk("async_shiftdr", {15'd0, ShiftDR}, 16'd0);
    chk("async_tdo_en", {15'd0, tdo_en}, 16'd0);
    #1 TRST = 1'b1;
    step(1'b0, 4'hC);
    step(1'b0, 4'hC);

    chk("queue_empty", exp_q.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
